// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Includes the binary-segment (XNOR-popcount) unit state and default sizes.
package riscv_pkg;

    localparam int XLEN = 64;

    localparam int BSEG_LANE_BITS = 16;
    localparam int BSEG_ACC_W     = 32;
    localparam int BSEG_NUM_CH    = 4;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    typedef enum logic [6:0] {
        OP_BS = 7'b0001011
    } op_inst_t;

    typedef enum logic [2:0] {
        F3_BS_SET = 3'd0,
        F3_BS_GET = 3'd1,
        F3_BS_IP  = 3'd2,
        F3_BS_GP0 = 3'd3,
        F3_BS_GP1 = 3'd4,
        F3_BS_GP2 = 3'd5,
        F3_BS_GP3 = 3'd6,
        F3_BS_GP4 = 3'd7
    } op_funct3_bs_t;

    typedef enum logic [3:0] {
        NONE          = 4'd0,
        ILLEGAL_INSTR = 4'd2
    } exception_cause_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bseg_state_t;

endpackage

// File: rtl/qnn_bseg_popcnt.sv
// One-chunk XNOR-popcount: number of bit positions where a and b agree.
module qnn_bseg_popcnt #(
    parameter int LANE_BITS = 16
) (
    input  logic [LANE_BITS-1:0]         a,
    input  logic [LANE_BITS-1:0]         b,
    output logic [$clog2(LANE_BITS):0]   cnt
);

    logic [LANE_BITS-1:0] same;

    always_comb begin
        same = ~(a ^ b);
        cnt  = '0;
        for (int i = 0; i < LANE_BITS; i++) begin
            cnt = cnt + {{$clog2(LANE_BITS){1'b0}}, same[i]};
        end
    end

endmodule

// File: rtl/qnn_bseg_unit.sv
// Binary-segment unit: per-channel signed accumulators fed by a
// multi-cycle XNOR-popcount inner product, with saturating update.
module qnn_bseg_unit
    import riscv_pkg::*;
#(
    parameter int LANE_BITS = BSEG_LANE_BITS,
    parameter int ACC_W     = BSEG_ACC_W,
    parameter int NUM_CH    = BSEG_NUM_CH
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  instruction_t     instr_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [4:0]       rd_o,
    output exception_cause_t exc_o,
    output logic             busy_o
);

    localparam int N  = XLEN / LANE_BITS;
    localparam int PW = $clog2(XLEN) + 1;
    localparam int LW = $clog2(LANE_BITS) + 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = ((ACC_W > PW + 1) ? ACC_W : PW + 1) + 2;

    bseg_state_t      state, state_nxt;
    logic             accept, illegal, is_set, is_get, last;
    logic [CW-1:0]    ch_in, ch_q;
    logic [XLEN-1:0]  op_a, op_b, result_q;
    logic [PW-1:0]    pcnt, p_next;
    logic [LW-1:0]    pc;
    logic [NW-1:0]    cnt;
    logic [4:0]       rd_q;
    exception_cause_t exc_q;
    logic [ACC_W-1:0] acc [NUM_CH];
    logic [ACC_W-1:0] acc_cur, sat;
    logic signed [SW-1:0] delta, sum;
    logic             unused_bits;

    assign unused_bits = ^{instr_i.funct7, instr_i.rs2, instr_i.rs1};

    assign ready_o = rstn_i && (state == IDLE) && !flush_i;
    assign accept  = valid_i && ready_o;
    assign valid_o = (state == DONE);
    assign busy_o  = (state != IDLE);
    assign result_o = result_q;
    assign rd_o     = rd_q;
    assign exc_o    = exc_q;

    assign ch_in   = (NUM_CH == 1) ? '0 : instr_i.rd[CW-1:0];
    assign illegal = (instr_i.opcode != OP_BS) ||
                     !(instr_i.funct3 == F3_BS_SET ||
                       instr_i.funct3 == F3_BS_GET ||
                       instr_i.funct3 == F3_BS_IP);
    assign is_set  = !illegal && (instr_i.funct3 == F3_BS_SET);
    assign is_get  = !illegal && (instr_i.funct3 == F3_BS_GET);

    qnn_bseg_popcnt #(
        .LANE_BITS(LANE_BITS)
    ) u_popcnt (
        .a  (op_a[LANE_BITS-1:0]),
        .b  (op_b[LANE_BITS-1:0]),
        .cnt(pc)
    );

    assign p_next  = pcnt + PW'(pc);
    assign last    = (cnt == NW'(N - 1));
    assign acc_cur = acc[ch_q];

    // Extra headroom bits make overflow detectable before clamping.
    always_comb begin
        delta = $signed({{(SW-PW-1){1'b0}}, p_next, 1'b0}) - SW'(XLEN);
        sum   = SW'($signed(acc_cur)) + delta;
        sat   = sum[ACC_W-1:0];
        if (sum[SW-1:ACC_W-1] != {(SW-ACC_W+1){sum[SW-1]}}) begin
            sat = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (!illegal && instr_i.funct3 == F3_BS_IP)
                              ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (flush_i || ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            op_a     <= '0;
            op_b     <= '0;
            pcnt     <= '0;
            cnt      <= '0;
            ch_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            exc_q    <= NONE;
        end else if (state == IDLE && accept) begin
            rd_q  <= instr_i.rd;
            ch_q  <= ch_in;
            op_a  <= rs1_data_i;
            op_b  <= rs2_data_i;
            pcnt  <= '0;
            cnt   <= '0;
            exc_q <= NONE;
            unique case (1'b1)
                illegal: begin
                    exc_q    <= ILLEGAL_INSTR;
                    result_q <= '0;
                end
                is_set: begin
                    result_q   <= XLEN'($signed(acc[ch_in]));
                    acc[ch_in] <= rs1_data_i[ACC_W-1:0];
                end
                is_get: begin
                    result_q <= XLEN'($signed(acc[ch_in]));
                    if (rs1_data_i[0]) begin
                        acc[ch_in] <= '0;
                    end
                end
                default: ;
            endcase
        end else if (state == BUSY && !flush_i) begin
            op_a <= op_a >> LANE_BITS;
            op_b <= op_b >> LANE_BITS;
            pcnt <= p_next;
            cnt  <= cnt + 1'b1;
            if (last) begin
                acc[ch_q] <= sat;
                result_q  <= XLEN'($signed(sat));
            end
        end
    end

endmodule

// File: tb/tb_qnn_bseg_unit.sv
// Directed self-checking bench for qnn_bseg_unit.
module tb_qnn_bseg_unit;
    import riscv_pkg::*;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    instruction_t     instr = '0;
    logic [XLEN-1:0]  rs1 = '0;
    logic [XLEN-1:0]  rs2 = '0;
    logic             flush = 1'b0;
    logic             valid_o;
    logic             ready_i = 1'b1;
    logic [XLEN-1:0]  result;
    logic [4:0]       rd;
    exception_cause_t exc;
    logic             busy;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    qnn_bseg_unit dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .instr_i   (instr),
        .rs1_data_i(rs1),
        .rs2_data_i(rs2),
        .flush_i   (flush),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result),
        .rd_o      (rd),
        .exc_o     (exc),
        .busy_o    (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f3, input logic [4:0] r,
                         input logic [63:0] a, input logic [63:0] b);
        instr = '{funct7: 7'd0, rs2: 5'd0, rs1: 5'd0,
                  funct3: f3, rd: r, opcode: OP_BS};
        rs1 = a;
        rs2 = b;
        valid_i = 1'b1;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [4:0] r,
                          input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat,
                          output logic [4:0] rdo,
                          output exception_cause_t e);
        int n;
        @(negedge clk);
        drive(f3, r, a, b);
        #1;
        n = 0;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 64'(n), 64'(0));
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) chk("result_timeout", 64'(lat), 64'(0));
        res = result;
        rdo = rd;
        e   = exc;
    endtask

    logic [63:0]      res;
    int               lat;
    logic [4:0]       rdo;
    exception_cause_t e;
    logic             seen;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready_o), 64'(0));
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_result", result, 64'(0));
        chk("rst_rd", 64'(rd), 64'(0));
        chk("rst_exc", 64'(exc), 64'(NONE));
        rstn = 1'b1;

        run_op(F3_BS_SET, 5'd1, 64'd5, 64'd0, res, lat, rdo, e);
        chk("set1_old", res, 64'd0);
        chk("set1_lat", 64'(lat), 64'd1);
        chk("set1_rd", 64'(rdo), 64'd1);
        chk("set1_exc", 64'(e), 64'(NONE));
        run_op(F3_BS_GET, 5'd1, 64'd0, 64'd0, res, lat, rdo, e);
        chk("get1_val", res, 64'd5);
        chk("get1_lat", 64'(lat), 64'd1);
        chk("get1_rd", 64'(rdo), 64'd1);

        run_op(F3_BS_SET, 5'd0, 64'd0, 64'd0, res, lat, rdo, e);
        run_op(F3_BS_IP, 5'd0, ONES, ONES, res, lat, rdo, e);
        chk("ip_ones", res, 64'd64);
        chk("ip_lat", 64'(lat), 64'd5);
        chk("ip_rd", 64'(rdo), 64'd0);
        run_op(F3_BS_IP, 5'd0, 64'd0, ONES, res, lat, rdo, e);
        chk("ip_zero", res, 64'd0);

        run_op(F3_BS_SET, 5'd2, 64'h7FFF_FFF0, 64'd0, res, lat, rdo, e);
        run_op(F3_BS_IP, 5'd2, 64'h1234_5678_9ABC_DEF0,
               64'h1234_5678_9ABC_DEF0, res, lat, rdo, e);
        chk("sat_max", res, 64'h0000_0000_7FFF_FFFF);
        run_op(F3_BS_SET, 5'd2, 64'h8000_0010, 64'd0, res, lat, rdo, e);
        chk("set2_old", res, 64'h0000_0000_7FFF_FFFF);
        run_op(F3_BS_IP, 5'd2, 64'h0F0F_0000_FFFF_1234,
               ~64'h0F0F_0000_FFFF_1234, res, lat, rdo, e);
        chk("sat_min", res, 64'hFFFF_FFFF_8000_0000);

        run_op(F3_BS_SET, 5'd1, 64'd10, 64'd0, res, lat, rdo, e);
        chk("set1b_old", res, 64'd5);
        run_op(F3_BS_IP, 5'd1, 64'h0000_0000_FFFF_FFFF, 64'd0,
               res, lat, rdo, e);
        chk("ip_half", res, 64'd10);
        run_op(F3_BS_IP, 5'd1, 64'hF0F0_F0F0_F0F0_F0F0,
               64'h0F0F_0F0F_0F0F_0F0F, res, lat, rdo, e);
        chk("ip_neg", res, 64'hFFFF_FFFF_FFFF_FFCA);

        // Flush in the second BUSY cycle.
        run_op(F3_BS_SET, 5'd3, 64'd100, 64'd0, res, lat, rdo, e);
        @(negedge clk);
        drive(F3_BS_IP, 5'd3, ONES, ONES);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        seen = valid_o;
        @(negedge clk);
        seen |= valid_o;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_ready", 64'(ready_o), 64'd1);
        repeat (6) begin
            @(negedge clk);
            seen |= valid_o;
        end
        chk("flush_novalid", 64'(seen), 64'd0);
        run_op(F3_BS_GET, 5'd3, 64'd0, 64'd0, res, lat, rdo, e);
        chk("flush_acc", res, 64'd100);

        // Consumer stall on a clearing GET.
        @(negedge clk);
        ready_i = 1'b0;
        drive(F3_BS_GET, 5'd1, 64'd1, 64'd0);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        chk("hold_valid0", 64'(valid_o), 64'd1);
        chk("hold_res0", result, 64'hFFFF_FFFF_FFFF_FFCA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(valid_o), 64'd1);
            chk("hold_res", result, 64'hFFFF_FFFF_FFFF_FFCA);
            chk("hold_rd", 64'(rd), 64'd1);
            chk("hold_ready", 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk("hold_release", 64'(ready_o), 64'd1);
        run_op(F3_BS_GET, 5'd1, 64'd0, 64'd0, res, lat, rdo, e);
        chk("get_cleared", res, 64'd0);

        run_op(F3_BS_GP3, 5'd7, ONES, ONES, res, lat, rdo, e);
        chk("gp3_exc", 64'(e), 64'(ILLEGAL_INSTR));
        chk("gp3_res", res, 64'd0);
        chk("gp3_lat", 64'(lat), 64'd1);
        chk("gp3_rd", 64'(rdo), 64'd7);
        run_op(F3_BS_GET, 5'd2, 64'd0, 64'd0, res, lat, rdo, e);
        chk("gp3_ch2", res, 64'hFFFF_FFFF_8000_0000);
        chk("gp3_exc_clr", 64'(e), 64'(NONE));
        run_op(F3_BS_GET, 5'd3, 64'd0, 64'd0, res, lat, rdo, e);
        chk("gp3_ch3", res, 64'd100);

        // Reset during an inner product.
        @(negedge clk);
        drive(F3_BS_IP, 5'd3, ONES, ONES);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ready", 64'(ready_o), 64'd0);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= valid_o;
        end
        chk("rst_mid_novalid", 64'(seen), 64'd0);
        run_op(F3_BS_GET, 5'd3, 64'd0, 64'd0, res, lat, rdo, e);
        chk("rst_mid_acc", res, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/qnn_bseg_unit.md
QNN_BSEG_UNIT -- requirements
Module: qnn_bseg_unit

Interface
REQ-001 SHALL have parameter LANE_BITS, default 16: XNOR-popcount bits processed per cycle; must divide riscv_pkg::XLEN.
REQ-002 SHALL have parameter ACC_W, default 32: signed accumulator width, 8..XLEN.
REQ-003 SHALL have parameter NUM_CH, default 4: accumulator channel count, power of 2, 1..32.
REQ-004 SHALL have ports, clock and reset first:
- clk_i  in  1  single clock; all logic on its rising edge.
- rstn_i  in  1  reset; synchronous, active-low.
- valid_i  in  1  instruction offered.
- ready_o  out  1  unit can accept.
- instr_i  in  instruction_t  opcode OP_BS; func3 is op_funct3_bs_t; channel = rd[log2(NUM_CH)-1:0].
- rs1_data_i  in  XLEN  operand 1.
- rs2_data_i  in  XLEN  operand 2.
- flush_i  in  1  kill in-flight op.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  sign-extended result.
- rd_o  out  5  destination register, copied from instr_i.rd.
- exc_o  out  exception_cause_t  NONE or ILLEGAL_INSTR.
- busy_o  out  1  FSM not IDLE.

Function
REQ-005 SHALL accept an instruction on a cycle where valid_i && ready_o; ready_o SHALL be 1 only in IDLE.
REQ-006 SHALL implement FSM states IDLE, BUSY, DONE: IDLE->BUSY on accepting F3_BS_IP; IDLE->DONE on accepting any other func3; BUSY->DONE after the last chunk; DONE->IDLE when ready_i=1.
REQ-007 F3_BS_SET SHALL load acc[ch] with rs1_data_i[ACC_W-1:0] and return the old acc[ch]; latency 1 (valid_o the cycle after accept).
REQ-008 F3_BS_GET SHALL return acc[ch]; if rs1_data_i[0]=1, acc[ch] SHALL clear to 0 in the same update; latency 1.
REQ-009 F3_BS_IP SHALL latch the operands, then process one LANE_BITS chunk per cycle from the LSB over N=XLEN/LANE_BITS cycles, summing popcount(~(rs1^rs2)) into a partial count P of width log2(XLEN)+1.
REQ-010 On completion SHALL compute acc[ch] + (2*P - XLEN), saturate to signed ACC_W, write the result to acc[ch] and return it; valid_o SHALL assert N+1 cycles after accept.
REQ-011 Saturation: results above 2^(ACC_W-1)-1 clamp to max and results below -2^(ACC_W-1) clamp to min; no wrap-around.
REQ-012 F3_BS_GP0..GP4 SHALL produce valid_o after 1 cycle with exc_o=ILLEGAL_INSTR and result_o=0, with no state change.
REQ-013 All other results SHALL report exc_o=NONE; result_o SHALL be the ACC_W value sign-extended to XLEN.
REQ-014 In DONE with ready_i=0, result_o, rd_o, exc_o and valid_o SHALL hold stable.
REQ-015 flush_i=1 in BUSY or DONE SHALL return the FSM to IDLE next cycle with valid_o=0 and no acc write; flush_i has priority over completion and over ready_i.
REQ-016 flush_i=1 in IDLE SHALL block acceptance that cycle (ready_o=0).
REQ-017 A SET or GET to the channel whose IP is in flight cannot occur, since single issue blocks it; no forwarding SHALL be required.

Reset
REQ-018 On rstn_i=0 at a clock edge: FSM=IDLE; every acc[ch]=0; P=0; valid_o=0; busy_o=0; result_o=0; rd_o=0; exc_o=NONE; ready_o=0 while rstn_i=0.
REQ-019 Reset mid-IP SHALL discard the operation without producing a result.

Structure
REQ-020 SHALL use riscv_pkg types (instruction_t, op_inst_t OP_BS, op_funct3_bs_t, exception_cause_t, XLEN); the bseg_state_t enum and the default LANE_BITS/ACC_W/NUM_CH constants SHALL be added to riscv_pkg.
REQ-021 SHALL place the chunk XNOR-popcount in one combinational sub-module, qnn_bseg_popcnt (LANE_BITS in, log2(LANE_BITS)+1 out); everything else stays in qnn_bseg_unit.

Verification (XLEN=64, LANE_BITS=16, ACC_W=32, NUM_CH=4)
REQ-022 SET ch1 rs1=5, then GET ch1 rs1=0 -> results 0 then 5; each valid_o 1 cycle after accept; rd_o matches instr rd.
REQ-023 SET ch0=0; IP ch0 rs1=rs2=all-ones -> result 64, valid_o exactly 5 cycles after accept; then IP rs1=0, rs2=all-ones -> result 0 (64-64).
REQ-024 SET ch2=0x7FFFFFF0; IP rs1=rs2 -> 0x7FFFFFFF saturated; SET ch2=0x80000010; IP rs1=~rs2 -> result_o=0xFFFFFFFF80000000.
REQ-025 IP issued, flush_i pulsed at cycle 2 of BUSY -> no valid_o, acc unchanged (GET returns prior value), ready_o=1 the next cycle.
REQ-026 Hold ready_i=0 for 3 cycles after a GET result -> outputs stable, ready_o=0; next instruction accepted the cycle after ready_i=1.
REQ-027 GP3 issued -> exc_o=ILLEGAL_INSTR, result_o=0, all acc unchanged.
